rrp_otf_converter: RTL and testbench

//  MSD-first on-the-fly converter from redundant signed-digit (rRp) form to two's complement.

---
 rtl/rrp_otf_converter.sv | 99 +++++++++
 tb/tb_rrp_otf_converter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rrp_otf_converter.sv
// rtl/rrp_otf_converter.sv - MSD-first signed-digit to two's complement on-the-fly converter
// Ercegovac-Lang Q/QM registers build the word one digit at a time with no final carry-propagate add.
module rrp_otf_converter #(
   parameter  int RADIX = 2,
   parameter  int WIDTH = 8,
   localparam int K     = $clog2(RADIX),
   localparam int D     = K + 1,
   localparam int OW    = K * WIDTH + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [D-1:0]  in_digit,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_value,
   output logic          out_err
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]        LAST  = CW'(WIDTH - 1);
   localparam logic signed [OW-1:0] R_VAL = OW'(RADIX);
   localparam logic signed [OW-1:0] R_M1  = OW'(RADIX - 1);
   localparam logic signed [OW-1:0] ONE   = OW'(1);
   localparam logic [D-1:0]         ILLEGAL = {1'b1, {K{1'b0}}};

   typedef enum logic {ACC, HOLD} state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic signed [OW-1:0]   q_reg;
   logic signed [OW-1:0]   qm_reg;
   logic signed [OW-1:0]   dig_ext;
   logic signed [OW-1:0]   q_sh;
   logic signed [OW-1:0]   qm_sh;
   logic signed [OW-1:0]   q_next;
   logic signed [OW-1:0]   qm_next;
   logic                   dig_neg;
   logic                   dig_pos;
   logic                   dig_bad;

   always_comb begin
      dig_ext = OW'($signed(in_digit));
      dig_neg = in_digit[D-1];
      dig_pos = !in_digit[D-1] && (|in_digit);
      dig_bad = (in_digit == ILLEGAL);
      q_sh    = q_reg <<< K;
      qm_sh   = qm_reg <<< K;
      // Negative digits borrow from QM, so the new Q never needs a carry chain across the word.
      q_next  = dig_neg ? (qm_sh + R_VAL + dig_ext) : (q_sh + dig_ext);
      qm_next = dig_pos ? (q_sh + dig_ext - ONE) : (qm_sh + R_M1 + dig_ext);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         cnt       <= '0;
         q_reg     <= '0;
         qm_reg    <= '1;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_value <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  q_reg  <= q_next;
                  qm_reg <= qm_next;
                  if (dig_bad)
                     out_err <= 1'b1;
                  if (cnt == LAST) begin
                     out_value <= q_next;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     cnt       <= '0;
                     state     <= HOLD;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  q_reg     <= '0;
                  qm_reg    <= '1;
                  out_err   <= 1'b0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_rrp_otf_converter.sv
// tb/tb_rrp_otf_converter.sv - directed and random checks of rrp_otf_converter at RADIX 2, 4 and 8
// Instances: 0 = RADIX 2 / WIDTH 8, 1 = RADIX 4 / WIDTH 4, 2 = RADIX 8 / WIDTH 4.
module tb_rrp_otf_converter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] iv = '0;
   logic [2:0] ordy = '0;
   logic [3:0] dig_bus = '0;
   wire  [2:0] iny;
   wire  [2:0] ovl;
   wire  [2:0] oer;
   wire  [8:0]  o2;
   wire  [8:0]  o4;
   wire  [12:0] o8;

   int n_checks = 0;
   int n_errors = 0;
   int wd[8];
   int wid[3] = '{8, 4, 4};
   int rad[3] = '{2, 4, 8};

   always #5 clk = ~clk;

   rrp_otf_converter #(.RADIX(2), .WIDTH(8)) u_r2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(iny[0]), .in_digit(dig_bus[1:0]),
      .out_valid(ovl[0]), .out_ready(ordy[0]), .out_value(o2), .out_err(oer[0]));

   rrp_otf_converter #(.RADIX(4), .WIDTH(4)) u_r4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(iny[1]), .in_digit(dig_bus[2:0]),
      .out_valid(ovl[1]), .out_ready(ordy[1]), .out_value(o4), .out_err(oer[1]));

   rrp_otf_converter #(.RADIX(8), .WIDTH(4)) u_r8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(iny[2]), .in_digit(dig_bus[3:0]),
      .out_valid(ovl[2]), .out_ready(ordy[2]), .out_value(o8), .out_err(oer[2]));

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int val(input int k);
      case (k)
         0:       return int'($signed(o2));
         1:       return int'($signed(o4));
         default: return int'($signed(o8));
      endcase
   endfunction

   function automatic int model(input int k);
      int v = 0;
      int p = 1;
      for (int i = wid[k] - 1; i >= 0; i--) begin
         v = v + wd[i] * p;
         p = p * rad[k];
      end
      return v;
   endfunction

   // exp_e=1 means the word carries an illegal digit and its value is not checked.
   task automatic run_word(input string tag, input int k, input int exp_v, input int exp_e,
                           input bit gaps, input int hold_cycles, input bit early);
      int w = wid[k];
      for (int i = 0; i < w; i++) begin
         int nb = gaps ? int'($urandom_range(0, 2)) : 0;
         for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            iv[k] = 1'b0;
            dig_bus = 4'($urandom);
         end
         @(negedge clk);
         if (i == w - 1) begin
            check({tag, "_valid_pre"}, int'(ovl[k]), 0);
            if (early) ordy[k] = 1'b1;
         end
         iv[k] = 1'b1;
         dig_bus = 4'(wd[i]);
      end
      @(negedge clk);
      iv[k] = 1'b0;
      check({tag, "_valid"}, int'(ovl[k]), 1);
      if (exp_e == 0) check({tag, "_value"}, val(k), exp_v);
      check({tag, "_err"}, int'(oer[k]), exp_e);
      if (early) begin
         @(negedge clk);
         ordy[k] = 1'b0;
         check({tag, "_hold1_valid"}, int'(ovl[k]), 0);
         check({tag, "_hold1_ready"}, int'(iny[k]), 1);
         return;
      end
      for (int c = 0; c < hold_cycles; c++) begin
         iv[k] = 1'b1;
         dig_bus = 4'($urandom);
         @(negedge clk);
         check({tag, "_bp_valid"}, int'(ovl[k]), 1);
         check({tag, "_bp_ready"}, int'(iny[k]), 0);
         if (exp_e == 0) check({tag, "_bp_value"}, val(k), exp_v);
         check({tag, "_bp_err"}, int'(oer[k]), exp_e);
      end
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      check({tag, "_done_valid"}, int'(ovl[k]), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", int'(ovl[0]), 0);
      check("rst_ready", int'(iny[0]), 1);
      check("rst_value", val(0), 0);
      check("rst_err", int'(oer[0]), 0);
      rst_n = 1'b1;

      wd = '{1, 0, 0, 0, 0, 0, 0, 0};
      run_word("r2_msb", 0, 128, 0, 1'b0, 0, 1'b0);
      wd = '{-1, -1, -1, -1, -1, -1, -1, -1};
      run_word("r2_neg", 0, -255, 0, 1'b0, 0, 1'b0);
      wd = '{1, -1, 1, -1, 1, -1, 1, -1};
      run_word("r2_alt", 0, 85, 0, 1'b0, 0, 1'b1);
      wd = '{0, 0, 0, 0, 0, 0, 1, 1};
      run_word("r2_after_hold1", 0, 3, 0, 1'b0, 0, 1'b0);

      wd = '{3, 3, 3, 3, 0, 0, 0, 0};
      run_word("r4_max", 1, 255, 0, 1'b0, 0, 1'b0);
      wd = '{-3, 0, 0, 1, 0, 0, 0, 0};
      run_word("r4_mix", 1, -191, 0, 1'b0, 0, 1'b0);
      wd = '{1, -3, -3, -3, 0, 0, 0, 0};
      run_word("r4_qm", 1, 1, 0, 1'b0, 0, 1'b0);
      wd = '{3, 3, 3, 3, 0, 0, 0, 0};
      run_word("r4_bp", 1, 255, 0, 1'b0, 5, 1'b0);
      wd = '{-3, 0, 0, 1, 0, 0, 0, 0};
      run_word("r4_after_bp", 1, -191, 0, 1'b0, 0, 1'b0);

      wd = '{7, 7, 7, 7, 0, 0, 0, 0};
      run_word("r8_max", 2, 4095, 0, 1'b0, 0, 1'b0);
      wd = '{-7, -7, -7, -7, 0, 0, 0, 0};
      run_word("r8_min", 2, -4095, 0, 1'b0, 0, 1'b0);

      wd = '{1, 0, 0, -2, 0, 1, 0, 0};
      run_word("r2_illegal", 0, 0, 1, 1'b0, 2, 1'b0);
      wd = '{0, 0, 0, 0, 0, 1, 0, 1};
      run_word("r2_after_illegal", 0, 5, 0, 1'b0, 0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         iv[0] = 1'b1;
         dig_bus = 4'(1);
      end
      @(negedge clk);
      iv[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", int'(ovl[0]), 0);
      check("midrst_ready", int'(iny[0]), 1);
      @(negedge clk);
      rst_n = 1'b1;
      wd = '{0, 0, 0, 0, 0, 0, 0, 1};
      run_word("r2_after_rst", 0, 1, 0, 1'b0, 0, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         int k = n % 3;
         int a = rad[k] - 1;
         for (int i = 0; i < wid[k]; i++)
            wd[i] = int'($urandom_range(0, 2 * a)) - a;
         run_word("rand", k, model(k), 0, 1'b1, int'($urandom_range(0, 2)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
